// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: opcodes, FSM encodings and default widths for the UART command engine
package uart_cmd_pkg;
  localparam int OPW_DEF  = 16;
  localparam int RESW_DEF = 40;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MAC = 2'd2;
  localparam logic [1:0] OP_RET = 2'd3;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_OPA  = 3'd1;
  localparam logic [2:0] ST_OPB  = 3'd2;
  localparam logic [2:0] ST_EXEC = 3'd3;
  localparam logic [2:0] ST_SEND = 3'd4;
  localparam logic [1:0] SER_IDLE = 2'd0;
  localparam logic [1:0] SER_SEND = 2'd1;
  localparam logic [1:0] SER_WAIT = 2'd2;
endpackage

// File: rtl/uart_resp_ser.sv
// uart_resp_ser: serialises a latched result word to uart_tx MSB byte first, pulses oDone after the last byte
module uart_resp_ser
  import uart_cmd_pkg::*;
#(
  parameter int RESW = RESW_DEF
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iGo,
  input  logic [RESW-1:0] iWord,
  input  logic            iTxBusy,
  input  logic            iTxDone,
  output logic [7:0]      oTxByte,
  output logic            oTxStart,
  output logic            oDone
);
  localparam int NR = RESW / 8;
  localparam int IW = $clog2(NR + 1);
  logic [1:0]      r_state;
  logic [IW-1:0]   r_idx;
  logic [RESW-1:0] r_word;
  logic [7:0]      r_tx_byte;
  logic            r_tx_start;
  logic [7:0]      w_byte;
  assign w_byte   = 8'(r_word >> {r_idx, 3'b000});
  assign oTxByte  = r_tx_byte;
  assign oTxStart = r_tx_start;
  assign oDone    = r_state == SER_WAIT && iTxDone && r_idx == '0;
  // One start pulse per byte; the next byte is only offered after uart_tx reports done and is idle
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= SER_IDLE;
      r_idx      <= '0;
      r_word     <= '0;
      r_tx_byte  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        SER_IDLE: if (iGo) begin
          r_word  <= iWord;
          r_idx   <= IW'(NR - 1);
          r_state <= SER_SEND;
        end
        SER_SEND: if (!iTxBusy) begin
          r_tx_byte  <= w_byte;
          r_tx_start <= 1'b1;
          r_state    <= SER_WAIT;
        end
        SER_WAIT: if (iTxDone) begin
          r_state <= r_idx == '0 ? SER_IDLE : SER_SEND;
          r_idx   <= r_idx == '0 ? r_idx : r_idx - 1'b1;
        end
        default: r_state <= SER_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_cmd_engine.sv
// uart_cmd_engine: parses UART opcode/operand frames, runs ADD/SUB/MAC into an accumulator, returns it on RET
// Optional inter-byte timeout while collecting operands is enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_engine
  import uart_cmd_pkg::*;
#(
  parameter int OPW     = OPW_DEF,
  parameter int RESW    = RESW_DEF,
  parameter int TIMEOUT = 1000
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic [7:0]      iRxByte,
  input  logic            iRxDone,
  input  logic            iTxBusy,
  input  logic            iTxDone,
  output logic [7:0]      oTxByte,
  output logic            oTxStart,
  output logic            oBusy,
  output logic            oErr,
  output logic [RESW-1:0] oAcc
);
  localparam int NB = OPW / 8;
  localparam int CW = $clog2(NB + 1);
  logic [2:0]       r_state;
  logic [1:0]       r_op;
  logic [OPW-1:0]   r_a, r_b;
  logic [CW-1:0]    r_cnt;
  logic [RESW-1:0]  r_acc;
  logic             r_err;
  logic             w_last, w_op_ok, w_go, w_done, w_tmo, w_frame;
  logic [OPW-1:0]   w_shift_a, w_shift_b;
  logic [2*OPW-1:0] w_prod;
  logic [RESW-1:0]  w_res;
  assign w_last    = r_cnt == CW'(NB - 1);
  assign w_op_ok   = iRxByte[7:2] == 6'd0;
  assign w_go      = r_state == ST_IDLE && iRxDone && w_op_ok && iRxByte[1:0] == OP_RET;
  assign w_frame   = r_state == ST_OPA || r_state == ST_OPB;
  assign w_shift_a = (r_a << 8) | OPW'(iRxByte);
  assign w_shift_b = (r_b << 8) | OPW'(iRxByte);
  assign w_prod    = r_a * r_b;
  assign oBusy     = r_state != ST_IDLE;
  assign oErr      = r_err;
  assign oAcc      = r_acc;
`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
  assign w_tmo = w_frame && !iRxDone && r_tmo == TW'(TIMEOUT - 1);
  // Inter-byte timer: restarts on every received byte and only runs while an operand frame is open
  always_ff @(posedge iClk) begin
    r_tmo <= (iRst || iRxDone || !w_frame) ? '0 : r_tmo + 1'b1;
  end
`else
  assign w_tmo = 1'b0;
`endif
  // EXEC result; operands are zero-extended to the accumulator width and wrap modulo 2^RESW
  always_comb begin
    w_res = r_op == OP_ADD ? RESW'(r_a) + RESW'(r_b) :
            r_op == OP_SUB ? RESW'(r_a) - RESW'(r_b) : r_acc + RESW'(w_prod);
  end
  // Frame parser and accumulator; errors flag bad opcodes, bytes arriving mid-send and timeouts
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= (iRxDone && ((r_state == ST_IDLE && !w_op_ok) || r_state == ST_SEND)) || w_tmo;
      case (r_state)
        ST_IDLE: if (iRxDone && w_op_ok) begin
          r_op    <= iRxByte[1:0];
          r_cnt   <= '0;
          r_state <= iRxByte[1:0] == OP_RET ? ST_SEND : ST_OPA;
        end
        ST_OPA: if (w_tmo) r_state <= ST_IDLE;
        else if (iRxDone) begin
          r_a     <= w_shift_a;
          r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
          r_state <= w_last ? ST_OPB : ST_OPA;
        end
        ST_OPB: if (w_tmo) r_state <= ST_IDLE;
        else if (iRxDone) begin
          r_b     <= w_shift_b;
          r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
          r_state <= w_last ? ST_EXEC : ST_OPB;
        end
        ST_EXEC: begin
          r_acc   <= w_res;
          r_state <= ST_IDLE;
        end
        ST_SEND: if (w_done) begin
          r_acc   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  uart_resp_ser #(.RESW(RESW)) u_ser (
    .iClk    (iClk),
    .iRst    (iRst),
    .iGo     (w_go),
    .iWord   (r_acc),
    .iTxBusy (iTxBusy),
    .iTxDone (iTxDone),
    .oTxByte (oTxByte),
    .oTxStart(oTxStart),
    .oDone   (w_done)
  );
endmodule
